filter_fetch: RTL and testbench

Read-side sequencer for the conv weight ROM (`filter_rom`). On `start` it walks every (output channel, input channel, tap) address and issues one ROM read per weight. It accounts for the ROM's fixed 1-cycle read latency and streams the weights to the conv engine over a valid/ready interface with tap/channel tags. A 2-entry output buffer absorbs backpressure, so no ROM data is lost or duplicated.

---
 rtl/filter_fetch.sv | 138 +++++++++++++
 tb/tb_filter_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_fetch.sv
// filter_fetch: sequences conv weight ROM reads and streams weights over valid/ready with tags
module filter_fetch #(
   parameter int N_TAP = 25,
   parameter int N_OC  = 6,
   parameter int N_IC  = 1,
   parameter int DW    = 16,
   parameter int FW    = 5,
   parameter int OCW   = 3,
   parameter int ICW   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   output logic           busy,
   output logic           done,
   output logic [FW-1:0]  aa_f,
   output logic [OCW-1:0] aa_oc,
   output logic [ICW-1:0] aa_ic,
   output logic           cena,
   input  logic [DW-1:0]  qa,
   output logic           w_valid,
   input  logic           w_ready,
   output logic [DW-1:0]  w_data,
   output logic [FW-1:0]  w_tap,
   output logic [OCW-1:0] w_oc,
   output logic [ICW-1:0] w_ic,
   output logic           w_last_tap,
   output logic           w_last
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_nxt;
   logic [FW-1:0]  r_f, r_if_f;
   logic [OCW-1:0] r_oc, r_if_oc;
   logic [ICW-1:0] r_ic, r_if_ic;
   logic           r_infl;
   logic [DW-1:0]  r_d [2];
   logic [FW-1:0]  r_t [2];
   logic [OCW-1:0] r_o [2];
   logic [ICW-1:0] r_i [2];
   logic           r_rd, r_wr;
   logic [1:0]     r_occ;
   logic           w_pop, w_push, w_issue, w_f_max, w_oc_max, w_ic_max, w_end;
   assign w_f_max  = r_f == FW'(N_TAP - 1);
   assign w_oc_max = r_oc == OCW'(N_OC - 1);
   assign w_ic_max = r_ic == ICW'(N_IC - 1);
   assign w_end    = w_f_max && w_oc_max && w_ic_max;
   assign w_valid  = r_occ != 2'd0;
   assign w_pop    = w_valid && w_ready;
   assign w_push   = r_infl && !abort;
   // a read may issue only if its data is guaranteed a buffer slot when it lands
   assign w_issue  = r_state == S_FETCH && !abort && (r_occ + 2'(r_infl) < 2'd2 + 2'(w_pop));
   assign cena     = w_issue;
   assign aa_f     = r_f;
   assign aa_oc    = r_oc;
   assign aa_ic    = r_ic;
   assign busy     = r_state == S_FETCH || r_state == S_DRAIN;
   assign done     = r_state == S_DONE;
   assign w_data   = r_d[r_rd];
   assign w_tap    = r_t[r_rd];
   assign w_oc     = r_o[r_rd];
   assign w_ic     = r_i[r_rd];
   assign w_last_tap = w_valid && w_tap == FW'(N_TAP - 1);
   assign w_last   = w_last_tap && w_oc == OCW'(N_OC - 1) && w_ic == ICW'(N_IC - 1);

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;

   // next state; DRAIN exits when the buffer empties this cycle so done follows the last handshake
   always_comb begin
      w_nxt = r_state;
      if (abort) w_nxt = S_IDLE;
      else case (r_state)
         S_IDLE:  if (start) w_nxt = S_FETCH;
         S_FETCH: if (w_issue && w_end) w_nxt = S_DRAIN;
         S_DRAIN: if (!r_infl && r_occ == {1'b0, w_pop}) w_nxt = S_DONE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // address counters (f inner, ic middle, oc outer) advance only on issue, so they wrap back to 0 after the sweep
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n || abort) begin
         if (!rst_n || abort) begin
            r_f  <= '0;
            r_ic <= '0;
            r_oc <= '0;
         end
      end else if (w_issue) begin
         r_f <= w_f_max ? '0 : r_f + 1'b1;
         if (w_f_max) r_ic <= w_ic_max ? '0 : r_ic + 1'b1;
         if (w_f_max && w_ic_max) r_oc <= w_oc_max ? '0 : r_oc + 1'b1;
      end

   // in-flight flag and the tags of the read whose data arrives next cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_infl  <= 1'b0;
         r_if_f  <= '0;
         r_if_oc <= '0;
         r_if_ic <= '0;
      end else begin
         r_infl <= w_issue;
         if (w_issue) begin
            r_if_f  <= r_f;
            r_if_oc <= r_oc;
            r_if_ic <= r_ic;
         end
      end

   // 2-entry output FIFO; qa captured the cycle after issue together with its tags
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_d[0] <= '0; r_d[1] <= '0;
         r_t[0] <= '0; r_t[1] <= '0;
         r_o[0] <= '0; r_o[1] <= '0;
         r_i[0] <= '0; r_i[1] <= '0;
         r_rd   <= 1'b0;
         r_wr   <= 1'b0;
         r_occ  <= 2'd0;
      end else if (abort) begin
         r_rd   <= 1'b0;
         r_wr   <= 1'b0;
         r_occ  <= 2'd0;
      end else begin
         if (w_push) begin
            r_d[r_wr] <= qa;
            r_t[r_wr] <= r_if_f;
            r_o[r_wr] <= r_if_oc;
            r_i[r_wr] <= r_if_ic;
            r_wr      <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
      end
endmodule

// File: tb/tb_filter_fetch.sv
// tb_filter_fetch: directed vectors plus a streaming scoreboard for filter_fetch
module tb_filter_fetch;
   localparam int NT = 25, NO = 6, NI = 1, TOT = NT * NO * NI;
   logic clk = 0, rst_n = 0, start = 0, abort = 0, w_ready = 0;
   logic busy, done, cena, w_valid, w_last_tap, w_last;
   logic [4:0] aa_f, w_tap;
   logic [2:0] aa_oc, w_oc;
   logic aa_ic, w_ic;
   logic [15:0] qa = 0, w_data;
   logic [8:0] aa_cat;
   logic [26:0] w_cat;
   assign aa_cat = {aa_oc, aa_ic, aa_f};
   assign w_cat  = {w_data, w_tap, w_oc, w_ic, w_last_tap, w_last};

   filter_fetch dut (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
      .aa_f(aa_f), .aa_oc(aa_oc), .aa_ic(aa_ic), .cena(cena), .qa(qa), .w_valid(w_valid),
      .w_ready(w_ready), .w_data(w_data), .w_tap(w_tap), .w_oc(w_oc), .w_ic(w_ic),
      .w_last_tap(w_last_tap), .w_last(w_last));

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] rom(int i);
      case (i)
         0:       return 16'd991;
         1:       return 16'd1857;
         149:     return 16'(-7533);
         default: return 16'(i * 613 + 17);
      endcase
   endfunction

   // synchronous ROM model: data appears the cycle after the read strobe
   always @(posedge clk) if (cena) qa <= rom(int'(aa_oc) * NT * NI + int'(aa_ic) * NT + int'(aa_f));

   int tests = 0, fails = 0;
   task automatic chk(string n, longint a, longint e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   bit mon_en = 0, have_prev = 0, pop;
   int exp_idx = 0, issued = 0, popped = 0, done_cnt = 0, last_hs = 0, t0 = 0, outst, k;
   logic p_cena, p_valid, p_ready;
   logic [8:0] p_aa;
   logic [26:0] p_w;

   // scoreboard: issue order and rule, address hold, output hold, stream contents, done timing
   always @(negedge clk) if (mon_en) begin
      outst = issued - popped;
      pop = w_valid && w_ready;
      chk("occ_bound", outst <= 2, 1);
      if (cena) begin
         k = issued;
         chk("issue_rule", outst - int'(pop) < 2, 1);
         chk("aa_f", aa_f, k % NT);
         chk("aa_oc", aa_oc, k / (NT * NI));
         chk("aa_ic", aa_ic, (k / NT) % NI);
         issued++;
      end
      if (have_prev && !p_cena) chk("aa_hold", aa_cat, p_aa);
      if (have_prev && p_valid && !p_ready) begin
         chk("valid_hold", w_valid, 1);
         chk("w_hold", w_cat, p_w);
      end
      if (pop) begin
         k = exp_idx;
         chk("w_data", w_data, rom(k));
         chk("w_tap", w_tap, k % NT);
         chk("w_oc", w_oc, k / (NT * NI));
         chk("w_ic", w_ic, (k / NT) % NI);
         chk("w_last_tap", w_last_tap, k % NT == NT - 1);
         chk("w_last", w_last, k == TOT - 1);
         popped++;
         exp_idx++;
         last_hs = cyc;
      end
      if (done) begin
         done_cnt++;
         chk("done_after_last", exp_idx, TOT);
         chk("done_timing", cyc - last_hs, 1);
      end
      p_cena = cena; p_valid = w_valid; p_ready = w_ready; p_aa = aa_cat; p_w = w_cat;
      have_prev = 1;
   end

   task automatic pulse_start();
      @(posedge clk); #1;
      exp_idx = 0; issued = 0; popped = 0; done_cnt = 0; have_prev = 0; mon_en = 1;
      t0 = cyc;
      start = 1;
      fork begin @(posedge clk); #1 start = 0; end join_none
   endtask

   task automatic wait_idx(int n);
      int b = 0;
      while (exp_idx < n && b < 2000) begin @(posedge clk); #1; b++; end
      chk("wait_idx_timeout", exp_idx >= n, 1);
   endtask

   task automatic wait_done(bit toggle);
      int b = 0;
      while (done_cnt == 0 && b < 2000) begin
         @(posedge clk); #1;
         if (toggle) w_ready = ~w_ready;
         b++;
      end
      chk("done_timeout", done_cnt, 1);
      chk("all_delivered", exp_idx, TOT);
   endtask

   typedef struct { int rel; logic cena; logic valid; logic done; logic busy; } vec_t;
   vec_t vt[9];

   initial begin
      vt[0] = '{0, 0, 0, 0, 0};
      vt[1] = '{1, 1, 0, 0, 1};
      vt[2] = '{2, 1, 0, 0, 1};
      vt[3] = '{3, 1, 1, 0, 1};
      vt[4] = '{150, 1, 1, 0, 1};
      vt[5] = '{151, 0, 1, 0, 1};
      vt[6] = '{152, 0, 1, 0, 1};
      vt[7] = '{153, 0, 0, 1, 0};
      vt[8] = '{154, 0, 0, 0, 0};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, cena, w_valid, w_last_tap, w_last, w_data, w_tap, w_oc, w_ic, aa_f, aa_oc, aa_ic}, 0);
      rst_n = 1;
      // full sweep with the consumer always ready: exact cycle timing
      w_ready = 1;
      pulse_start();
      for (int r = 0; r <= 155; r++) begin
         @(negedge clk);
         for (int i = 0; i < 9; i++) if (vt[i].rel == r) begin
            chk($sformatf("cena@%0d", r), cena, vt[i].cena);
            chk($sformatf("w_valid@%0d", r), w_valid, vt[i].valid);
            chk($sformatf("done@%0d", r), done, vt[i].done);
            chk($sformatf("busy@%0d", r), busy, vt[i].busy);
         end
      end
      chk("t1_count", exp_idx, TOT);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_last_hs", last_hs - t0, 152);
      // consumer ready alternating every cycle
      pulse_start();
      wait_done(1);
      // long stall mid-sweep, with a start pulse while busy that must be ignored
      w_ready = 1;
      pulse_start();
      wait_idx(30);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      wait_idx(40);
      w_ready = 0;
      repeat (20) begin @(posedge clk); #1; end
      chk("stall_buffered", issued - popped, 2);
      chk("stall_busy", busy, 1);
      w_ready = 1;
      wait_done(0);
      // abort with a full buffer, then restart from the first address
      pulse_start();
      wait_idx(70);
      w_ready = 0;
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_full", issued - popped, 2);
      chk("abort_pre_valid", w_valid, 1);
      abort = 1;
      mon_en = 0;
      @(posedge clk); #1;
      abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", w_valid, 0);
      chk("abort_cena", cena, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_idle_valid", w_valid, 0);
      end
      w_ready = 1;
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      chk("restart_cena", cena, 1);
      chk("restart_addr", aa_cat, 0);
      wait_done(0);
      // asynchronous reset in mid-sweep
      pulse_start();
      wait_idx(30);
      mon_en = 0;
      rst_n = 0;
      #1;
      chk("midreset_outputs", {busy, done, cena, w_valid, w_last_tap, w_last, w_data, w_tap, w_oc, w_ic, aa_f, aa_oc, aa_ic}, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midreset_no_done", done, 0);
      end
      @(posedge clk); #1;
      rst_n = 1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
